// File: rtl/lifo_arb.sv
// Round-robin arbiter sharing one LIFO between N clients; pop data returns one cycle after grant.
// Define LIFO_ARB_PRIO0_EN to give client 0 fixed priority over the round-robin order.

module lifo_arb_lane #(
  parameter int DWIDTH = 16
) (
  input  logic              i_req,
  input  logic              i_wr,
  input  logic              i_full,
  input  logic              i_empty,
  input  logic              i_gnt,
  input  logic [DWIDTH-1:0] i_data,
  output logic              o_elig,
  output logic              o_push,
  output logic              o_pop,
  output logic [DWIDTH-1:0] o_wdata
);
  assign o_elig  = i_req & (i_wr ? ~i_full : ~i_empty);
  assign o_push  = i_gnt & i_wr;
  assign o_pop   = i_gnt & ~i_wr;
  assign o_wdata = o_push ? i_data : '0;
endmodule

module lifo_arb #(
  parameter int DWIDTH = 16,
  parameter int N      = 4
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic [N-1:0]          req_i,
  input  logic [N-1:0]          wr_i,
  input  logic [N*DWIDTH-1:0]   data_i,
  output logic [N-1:0]          gnt_o,
  output logic [DWIDTH-1:0]     rdata_o,
  output logic [N-1:0]          rvalid_o,
  output logic                  lifo_wrreq_o,
  output logic [DWIDTH-1:0]     lifo_data_o,
  output logic                  lifo_rdreq_o,
  input  logic [DWIDTH-1:0]     lifo_q_i,
  input  logic                  lifo_empty_i,
  input  logic                  lifo_full_i
);
  localparam int PW = $clog2(N);

  logic [N-1:0]             w_elig, w_gnt, w_push, w_pop;
  logic [N-1:0][DWIDTH-1:0] w_wdata;
  logic [PW-1:0]            r_ptr, w_ptr_nxt, w_idx;
  logic [PW:0]              w_cand;
  logic                     w_any;
  logic [N-1:0]             r_vld_pipe;
  logic [DWIDTH-1:0]        w_data_or;

  for (genvar g = 0; g < N; g++) begin : g_lane
    lifo_arb_lane #(.DWIDTH(DWIDTH)) u_lane (
      .i_req   (req_i[g]),
      .i_wr    (wr_i[g]),
      .i_full  (lifo_full_i),
      .i_empty (lifo_empty_i),
      .i_gnt   (w_gnt[g]),
      .i_data  (data_i[g*DWIDTH +: DWIDTH]),
      .o_elig  (w_elig[g]),
      .o_push  (w_push[g]),
      .o_pop   (w_pop[g]),
      .o_wdata (w_wdata[g])
    );
  end

  // Search from r_ptr upward with wrap; first eligible client wins.
  always_comb begin
    w_any  = 1'b0;
    w_idx  = '0;
    w_cand = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_cand >= (PW+1)'(N)) w_cand = w_cand - (PW+1)'(N);
      if (!w_any && w_elig[w_cand[PW-1:0]]) begin
        w_any = 1'b1;
        w_idx = w_cand[PW-1:0];
      end
    end
`ifdef LIFO_ARB_PRIO0_EN
    if (w_elig[0]) begin
      w_any = 1'b1;
      w_idx = '0;
    end
`endif
    // Grants are suppressed combinationally while reset is held.
    if (!arstn_i) w_any = 1'b0;
  end

  always_comb begin
    w_gnt = '0;
    if (w_any) w_gnt[w_idx] = 1'b1;
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_any) w_ptr_nxt = (w_idx == PW'(N-1)) ? '0 : w_idx + PW'(1);
`ifdef LIFO_ARB_PRIO0_EN
    if (w_any && w_idx == '0) w_ptr_nxt = r_ptr;
`endif
  end

  always_comb begin
    w_data_or = '0;
    for (int i = 0; i < N; i++) w_data_or = w_data_or | w_wdata[i];
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_ptr      <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_ptr      <= w_ptr_nxt;
      r_vld_pipe <= w_pop;
    end
  end

  assign gnt_o        = w_gnt;
  assign lifo_wrreq_o = |w_push;
  assign lifo_rdreq_o = |w_pop;
  assign lifo_data_o  = w_data_or;
  assign rdata_o      = lifo_q_i;
  assign rvalid_o     = r_vld_pipe;
endmodule

// File: tb/tb_lifo_arb.sv
// Bench for lifo_arb: behavioural 8-deep LIFO, reference arbiter model and pop-data scoreboard.
module tb_lifo_arb;
  localparam int N = 4, DW = 16, DEPTH = 8;

  logic              clk_i = 1'b0, arstn_i = 1'b0;
  logic [N-1:0]      req_i = '0, wr_i = '0;
  logic [N*DW-1:0]   data_i = '0;
  logic [N-1:0]      gnt_o, rvalid_o;
  logic [DW-1:0]     rdata_o, lifo_data_o, lifo_q_i;
  logic              lifo_wrreq_o, lifo_rdreq_o, lifo_empty_i, lifo_full_i;

  always #5 clk_i = ~clk_i;

  lifo_arb #(.DWIDTH(DW), .N(N)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .req_i(req_i), .wr_i(wr_i), .data_i(data_i),
    .gnt_o(gnt_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .lifo_wrreq_o(lifo_wrreq_o), .lifo_data_o(lifo_data_o), .lifo_rdreq_o(lifo_rdreq_o),
    .lifo_q_i(lifo_q_i), .lifo_empty_i(lifo_empty_i), .lifo_full_i(lifo_full_i)
  );

  // attached LIFO: registered read data, not cleared by the arbiter reset
  logic [DW-1:0] lmem [DEPTH];
  int            ltop = 0;
  logic [DW-1:0] lq = '0;
  always @(posedge clk_i) begin
    if (lifo_wrreq_o) begin
      lmem[ltop] <= lifo_data_o;
      ltop       <= ltop + 1;
    end else if (lifo_rdreq_o) begin
      lq   <= lmem[ltop-1];
      ltop <= ltop - 1;
    end
  end
  assign lifo_q_i     = lq;
  assign lifo_empty_i = (ltop == 0);
  assign lifo_full_i  = (ltop == DEPTH);

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  typedef struct { int due; logic [N-1:0] vmask; logic [DW-1:0] data; } rd_t;
  rd_t           exp_q[$];
  logic [DW-1:0] ref_stk[$];
  int            mptr = 0;

  logic [N-1:0]  mon_ev;
  logic [DW-1:0] mon_ed;
  always @(negedge clk_i) begin
    mon_ev = '0;
    mon_ed = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_ev = exp_q[0].vmask;
      mon_ed = exp_q[0].data;
      void'(exp_q.pop_front());
      chk("rdata", rdata_o, mon_ed);
    end
    chk("rvalid", rvalid_o, mon_ev);
  end

  function automatic int pick(input logic [N-1:0] el, input int ptr);
`ifdef LIFO_ARB_PRIO0_EN
    if (el[0]) return 0;
`endif
    for (int k = 0; k < N; k++)
      if (el[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N*DW-1:0] mkd(input int seed);
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(i * 4096 + (seed & 'hfff));
    return d;
  endfunction

  // one cycle of stimulus, called just after a rising edge
  task automatic op(input logic [N-1:0] req, input logic [N-1:0] wr,
                    input logic [N*DW-1:0] d, input string tag);
    logic [N-1:0]  el, eg;
    logic          ew, er;
    logic [DW-1:0] ed;
    rd_t           e;
    int            g;
    req_i = req; wr_i = wr; data_i = d;
    @(negedge clk_i);
    for (int i = 0; i < N; i++)
      el[i] = req[i] && (wr[i] ? (ref_stk.size() < DEPTH) : (ref_stk.size() > 0));
    g  = pick(el, mptr);
    eg = '0; ew = 1'b0; er = 1'b0; ed = '0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      ew    = wr[g];
      er    = !wr[g];
      if (wr[g]) ed = d[g*DW +: DW];
    end
    chk({tag, ".gnt"},   gnt_o,        eg);
    chk({tag, ".wrreq"}, lifo_wrreq_o, ew);
    chk({tag, ".rdreq"}, lifo_rdreq_o, er);
    chk({tag, ".wdata"}, lifo_data_o,  ed);
    if (g >= 0) begin
      if (wr[g]) ref_stk.push_back(d[g*DW +: DW]);
      else begin
        e.due = cyc + 1; e.vmask = eg; e.data = ref_stk.pop_back();
        exp_q.push_back(e);
      end
`ifdef LIFO_ARB_PRIO0_EN
      if (g != 0) mptr = (g + 1) % N;
`else
      mptr = (g + 1) % N;
`endif
    end
    @(posedge clk_i); #1;
    req_i = '0; wr_i = '0; data_i = '0;
  endtask

  // reset asserted mid-cycle, checked before the next edge, released on a falling edge
  task automatic mid_reset(input string tag);
    #1 arstn_i = 1'b0;
    exp_q.delete();
    mptr = 0;
    req_i = 4'b1111; wr_i = 4'b0000;
    #1;
    chk({tag, ".rvalid"}, rvalid_o, 0);
    chk({tag, ".gnt"},    gnt_o,    0);
    chk({tag, ".rdreq"},  lifo_rdreq_o, 0);
    @(negedge clk_i);
    req_i = '0; wr_i = '0;
    arstn_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  initial begin
    // reset with pushes pending: all lifo drive must stay quiet
    req_i = 4'b1111; wr_i = 4'b1111; data_i = mkd(1);
    #2;
    chk("rst.gnt",   gnt_o,        0);
    chk("rst.wrreq", lifo_wrreq_o, 0);
    chk("rst.rdreq", lifo_rdreq_o, 0);
    chk("rst.wdata", lifo_data_o,  0);
    chk("rst.rvalid", rvalid_o,    0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst2.gnt", gnt_o, 0);
    req_i = '0; wr_i = '0; data_i = '0;
    arstn_i = 1'b1;
    @(posedge clk_i); #1;

    // client 1 pushes two words, client 2 pops them back in reverse
    op(4'b0010, 4'b0010, 64'h0000_0000_A5A5_0000, "t33.push0");
    op(4'b0010, 4'b0010, 64'h0000_0000_1234_0000, "t33.push1");
    op(4'b0100, 4'b0000, '0, "t33.pop0");
    op(4'b0100, 4'b0000, '0, "t33.pop1");
    op(4'b0000, 4'b0000, '0, "t33.idle");

    // pop then reset one cycle later: no rvalid, pointer back to 0
    op(4'b0010, 4'b0010, 64'h0000_0000_BEEF_0000, "t37.push");
    op(4'b0100, 4'b0000, '0, "t37.pop");
    mid_reset("t37.rst");
    op(4'b1010, 4'b1010, mkd(2), "t37.first");
    op(4'b1000, 4'b0000, '0, "t37.drain");
    op(4'b0000, 4'b0000, '0, "t37.idle");
    #1 arstn_i = 1'b0;
    mptr = 0;
    @(negedge clk_i);
    arstn_i = 1'b1;
    @(posedge clk_i); #1;

    // four continuous pushers from pointer 0, then fill to the brim
    for (int c = 0; c < 6; c++) op(4'b1111, 4'b1111, mkd(10 + c), "t34.rr");
    op(4'b0001, 4'b0001, mkd(20), "t25.push7");
    op(4'b0001, 4'b0001, mkd(21), "t25.push8");
    op(4'b0011, 4'b0001, mkd(22), "t36.full");
    op(4'b0011, 4'b0001, mkd(23), "t36.refill");
    for (int c = 0; c < DEPTH; c++) op(4'b1000, 4'b0000, '0, "drain");
    op(4'b1000, 4'b0000, '0, "t26.empty");

    // empty lifo: pop requests skipped until the push lands
    op(4'b1101, 4'b0100, mkd(30), "t35.push");
    op(4'b1001, 4'b0000, '0, "t35.pop");
    op(4'b1001, 4'b0000, '0, "t35.empty");
    op(4'b0000, 4'b0000, '0, "end.idle");
    repeat (2) @(posedge clk_i);
    chk("end.sb", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lifo_arb.md
LIFO_ARB -- requirements
Module: lifo_arb

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, meaning data word width (matches attached lifo).
REQ-002 SHALL have parameter N, default 4, meaning number of requesters (2..8).
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock; all state on rising edge.
REQ-004 SHALL have port arstn_i, input, 1, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port req_i, input, N, meaning per-client operation request.
REQ-006 SHALL have port wr_i, input, N, meaning per-client op type (1 = push, 0 = pop).
REQ-007 SHALL have port data_i, input, N*DWIDTH, meaning push data; client i at bits [i*DWIDTH +: DWIDTH].
REQ-008 SHALL have port gnt_o, output, N, meaning one-hot grant; the op transfers in the cycle where req_i[i] and gnt_o[i] are both high.
REQ-009 SHALL have port rdata_o, output, DWIDTH, meaning pop result, shared by all clients.
REQ-010 SHALL have port rvalid_o, output, N, meaning one-hot qualifier for rdata_o.
REQ-011 SHALL have ports lifo_wrreq_o (output, 1), lifo_data_o (output, DWIDTH) and lifo_rdreq_o (output, 1), meaning drive of the lifo.
REQ-012 SHALL have ports lifo_q_i (input, DWIDTH), lifo_empty_i (input, 1) and lifo_full_i (input, 1), meaning lifo status and read data.

Function
REQ-013 Client i SHALL be eligible when req_i[i] && (wr_i[i] ? !lifo_full_i : !lifo_empty_i).
REQ-014 gnt_o SHALL be combinational, at most one bit set, zero when no client is eligible.
REQ-015 Ineligible requesters SHALL be skipped without a grant; they hold req_i until granted.
REQ-016 Round-robin: the search SHALL start at rr_ptr and wrap N-1 -> 0; the first eligible client is granted.
REQ-017 rr_ptr SHALL load (granted index + 1) mod N on each grant and hold otherwise.
REQ-018 Push grant to i: lifo_wrreq_o = 1 and lifo_data_o = data_i slice i in the same cycle.
REQ-019 Pop grant to i: lifo_rdreq_o = 1 in the same cycle.
REQ-020 lifo_wrreq_o and lifo_rdreq_o SHALL never both be high; they are 0 with no grant.
REQ-021 lifo_data_o SHALL be 0 when there is no push grant.
REQ-022 Pop latency: rvalid_o[i] SHALL be high exactly one cycle after a pop grant, with rdata_o = lifo_q_i in that cycle.
REQ-023 rdata_o SHALL be lifo_q_i, unregistered; it is meaningful only when rvalid_o != 0.
REQ-024 Back-to-back grants, one per cycle, SHALL be sustained indefinitely (100% lifo utilisation).
REQ-025 Push into a lifo holding 2**AWIDTH-1 words followed by lifo_full_i: subsequent pushes SHALL be withheld and pops still granted.
REQ-026 With lifo_empty_i high and only pop requests pending: gnt_o = 0 and lifo_rdreq_o = 0.

Reset
REQ-027 arstn_i low SHALL immediately force rr_ptr = 0 and rvalid_o = 0, independent of clk_i.
REQ-028 gnt_o SHALL be 0 during reset; lifo_wrreq_o, lifo_rdreq_o and lifo_data_o SHALL be 0 during reset.
REQ-029 A pop granted in the cycle before reset assertion SHALL produce no rvalid_o.
REQ-030 The first grant after release SHALL follow REQ-016 from rr_ptr = 0.

Configuration
REQ-031 Macro LIFO_ARB_PRIO0_EN defined: client 0, when eligible, SHALL be granted regardless of rr_ptr, and rr_ptr SHALL not update on client 0 grants.
REQ-032 Macro LIFO_ARB_PRIO0_EN undefined: client 0 SHALL be a plain round-robin member per REQ-016/REQ-017.

Verification
REQ-033 Reset, then client 1 pushes 0xA5A5, 0x1234; client 2 pops twice -> rdata_o 0x1234 then 0xA5A5, each with rvalid_o = 4'b0100.
REQ-034 All 4 clients request pushes continuously from rr_ptr = 0 -> grant order 0,1,2,3,0,... with one grant per cycle.
REQ-035 Lifo empty, clients 0 and 3 pop while client 2 pushes -> only client 2 is granted; the following cycle (non-empty) a pop is granted.
REQ-036 Fill until lifo_full_i = 1; client 0 pushes while client 1 pops -> only client 1 is granted and no lifo_wrreq_o occurs.
REQ-037 Assert arstn_i mid-cycle one cycle after a pop grant -> rvalid_o = 0 immediately and the next grant after release goes to the lowest eligible index.
REQ-038 With LIFO_ARB_PRIO0_EN and all 4 clients pushing continuously -> client 0 is granted every cycle; without the macro -> order as REQ-034.
